// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int          PC_INCR    = 4;
  localparam logic [31:0] INSTR_NULL = 32'h0;

  // Entry layout at the default 32-bit XLEN; fetch_queue mirrors it at its own XLEN.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch buffer: entries are allocated at tail, filled in order at fill,
// and dequeued at head. A flush empties the whole buffer in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                       stage_clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       alloc,
  input  logic [XLEN-1:0]            alloc_pc,
  input  logic                       fill,
  input  logic [31:0]                fill_instr,
  input  logic                       deq,
  output logic                       head_filled,
  output logic [XLEN-1:0]            head_pc,
  output logic [31:0]                head_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } slot_t;

  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W-1:0] fill_reg;
  logic [PTR_W-1:0] head_reg;
  logic [CNT_W-1:0] count_reg;

  logic [XLEN-1:0] pc_w     [DEPTH];
  logic [31:0]     instr_w  [DEPTH];
  logic            filled_w [DEPTH];

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    slot_t entry_reg;

    // filled is cleared on dequeue so a stale slot never looks valid when head wraps onto it
    always_ff @(posedge stage_clk or posedge reset) begin
      if (reset) begin
        entry_reg <= '0;
      end else if (flush) begin
        entry_reg <= '0;
      end else if (alloc && tail_reg == PTR_W'(gi)) begin
        entry_reg <= '{pc: alloc_pc, instr: INSTR_NULL, filled: 1'b0};
      end else if (fill && fill_reg == PTR_W'(gi)) begin
        entry_reg.instr  <= fill_instr;
        entry_reg.filled <= 1'b1;
      end else if (deq && head_reg == PTR_W'(gi)) begin
        entry_reg.filled <= 1'b0;
      end
    end

    assign pc_w[gi]     = entry_reg.pc;
    assign instr_w[gi]  = entry_reg.instr;
    assign filled_w[gi] = entry_reg.filled;
  end

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      tail_reg  <= '0;
      fill_reg  <= '0;
      head_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      tail_reg  <= '0;
      fill_reg  <= '0;
      head_reg  <= '0;
      count_reg <= '0;
    end else begin
      tail_reg  <= tail_reg + PTR_W'(alloc);
      fill_reg  <= fill_reg + PTR_W'(fill);
      head_reg  <= head_reg + PTR_W'(deq);
      count_reg <= count_reg + CNT_W'(alloc) - CNT_W'(deq);
    end
  end

  assign head_filled = filled_w[head_reg];
  assign head_pc     = pc_w[head_reg];
  assign head_instr  = instr_w[head_reg];
  assign count       = count_reg;

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage with decoupled prefetch queue and in-order memory responses.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN            = 32,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = '0
) (
  input  logic            stage_clk,
  input  logic            reset,
  input  logic            stage_ena,
  input  logic            stage_x,
  input  logic            take_new_pc,
  input  logic [XLEN-1:0] pc_new,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [31:0]     dec_instr,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_pc_next,
  output logic [XLEN-1:0] fetch_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall,
  output logic [31:0]     perf_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int OUT_W = $clog2(MAX_OUTSTANDING+1);
  localparam int SUM_W = OUT_W + 1;

  logic [XLEN-1:0]  fetch_pc_reg;
  logic [OUT_W-1:0] inflight_reg;
  logic [OUT_W-1:0] drop_cnt_reg;
  logic [OUT_W-1:0] drop_flush;
  logic [SUM_W-1:0] outstanding;
  logic [CNT_W-1:0] q_count;

  logic kill;
  logic redirect;
  logic flush;
  logic grant;
  logic rsp_drop;
  logic rsp_fill;
  logic deq;
  logic head_filled;
  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_instr;

  assign kill     = stage_x;
  assign redirect = take_new_pc & stage_ena & ~stage_x;
  assign flush    = kill | redirect;

  // Stale responses still to be discarded count against the outstanding budget
  assign outstanding = SUM_W'(inflight_reg) + SUM_W'(drop_cnt_reg);
  assign imem_req    = stage_ena & ~stage_x & ~take_new_pc &
                       (q_count < CNT_W'(DEPTH)) &
                       (outstanding < SUM_W'(MAX_OUTSTANDING));
  assign imem_addr   = fetch_pc_reg;
  assign fetch_pc    = fetch_pc_reg;
  assign grant       = imem_req & imem_gnt;

  assign rsp_drop   = imem_rvalid & (drop_cnt_reg != '0);
  assign rsp_fill   = imem_rvalid & (drop_cnt_reg == '0) & ~flush;
  assign drop_flush = drop_cnt_reg + inflight_reg - OUT_W'(imem_rvalid);

  assign dec_valid   = stage_ena & ~stage_x & ~take_new_pc & head_filled;
  assign deq         = dec_valid & dec_ready;
  assign dec_instr   = dec_valid ? head_instr : INSTR_NULL;
  assign dec_pc      = dec_valid ? head_pc : '0;
  assign dec_pc_next = dec_pc + XLEN'(PC_INCR);

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
    end else if (kill) begin
      fetch_pc_reg <= RESET_PC;
      inflight_reg <= '0;
      drop_cnt_reg <= drop_flush;
    end else if (redirect) begin
      fetch_pc_reg <= pc_new;
      inflight_reg <= '0;
      drop_cnt_reg <= drop_flush;
    end else begin
      if (grant) begin
        fetch_pc_reg <= fetch_pc_reg + XLEN'(PC_INCR);
      end
      inflight_reg <= inflight_reg + OUT_W'(grant) - OUT_W'(rsp_fill);
      drop_cnt_reg <= drop_cnt_reg - OUT_W'(rsp_drop);
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_queue (
    .stage_clk   (stage_clk),
    .reset       (reset),
    .flush       (flush),
    .alloc       (grant),
    .alloc_pc    (fetch_pc_reg),
    .fill        (rsp_fill),
    .fill_instr  (imem_rdata),
    .deq         (deq),
    .head_filled (head_filled),
    .head_pc     (head_pc),
    .head_instr  (head_instr),
    .count       (q_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_reg;
  logic [31:0] perf_stall_reg;
  logic [31:0] perf_flushed_reg;

  always_ff @(posedge stage_clk or posedge reset) begin
    if (reset) begin
      perf_fetched_reg <= '0;
      perf_stall_reg   <= '0;
      perf_flushed_reg <= '0;
    end else begin
      if (deq) begin
        perf_fetched_reg <= perf_fetched_reg + 32'd1;
      end
      if (stage_ena && dec_ready && !dec_valid) begin
        perf_stall_reg <= perf_stall_reg + 32'd1;
      end
      if (flush) begin
        perf_flushed_reg <= perf_flushed_reg + 32'(q_count);
      end
    end
  end

  assign perf_fetched = perf_fetched_reg;
  assign perf_stall   = perf_stall_reg;
  assign perf_flushed = perf_flushed_reg;
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: vector table plus hand-written corner sequences.
module tb_fetch_queue_unit;

  logic        stage_clk = 1'b0;
  logic        reset = 1'b1;
  logic        stage_ena = 1'b0;
  logic        stage_x = 1'b0;
  logic        take_new_pc = 1'b0;
  logic [31:0] pc_new = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_next;
  logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
  logic [31:0] perf_flushed;
`endif

  fetch_queue_unit #(
    .XLEN            (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_PC        (32'h0)
  ) dut (
    .stage_clk   (stage_clk),
    .reset       (reset),
    .stage_ena   (stage_ena),
    .stage_x     (stage_x),
    .take_new_pc (take_new_pc),
    .pc_new      (pc_new),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_instr   (dec_instr),
    .dec_pc      (dec_pc),
    .dec_pc_next (dec_pc_next),
    .fetch_pc    (fetch_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall),
    .perf_flushed (perf_flushed)
`endif
  );

  initial forever #5 stage_clk = ~stage_clk;

  int n_vec = 0;
  int n_bad = 0;
  logic [31:0] mem_q[$];

  typedef struct {
    logic        ena;
    logic        take;
    logic [31:0] pcn;
    logic        gnt;
    logic        ready;
    logic        men;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_dv;
    logic [31:0] exp_dpc;
  } vec_t;

  vec_t vecs[18];

  function automatic logic [31:0] f_instr(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic vec_t mk(input logic ena, input logic take, input logic [31:0] pcn,
                              input logic gnt, input logic ready, input logic men,
                              input logic exp_req, input logic [31:0] exp_addr,
                              input logic exp_dv, input logic [31:0] exp_dpc);
    vec_t v;
    v.ena = ena; v.take = take; v.pcn = pcn; v.gnt = gnt; v.ready = ready; v.men = men;
    v.exp_req = exp_req; v.exp_addr = exp_addr; v.exp_dv = exp_dv; v.exp_dpc = exp_dpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // One clock cycle: drive at the falling edge, let the memory model answer the oldest
  // pending request, settle, then record any grant for a response in the next cycle.
  task automatic cyc(input logic ena, input logic x, input logic take, input logic [31:0] pcn,
                     input logic gnt, input logic ready, input logic men);
    @(negedge stage_clk);
    stage_ena   = ena;
    stage_x     = x;
    take_new_pc = take;
    pc_new      = pcn;
    imem_gnt    = gnt;
    dec_ready   = ready;
    if (men && mem_q.size() > 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = f_instr(mem_q.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    if (imem_req && imem_gnt) mem_q.push_back(imem_addr);
  endtask

  task automatic do_reset;
    @(negedge stage_clk);
    reset = 1'b1; stage_ena = 1'b0; stage_x = 1'b0; take_new_pc = 1'b0; pc_new = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0; dec_ready = 1'b0;
    mem_q.delete();
    repeat (2) @(negedge stage_clk);
    #1;
    chk("rst_fetch_pc", fetch_pc, 32'h0);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_pc", dec_pc, 32'h0);
    chk("rst_dec_instr", dec_instr, 32'h0);
    @(negedge stage_clk);
    reset = 1'b0;
    #1;
    chk("rst_req_disabled", 32'(imem_req), 32'd0);
  endtask

  int          deq_n;
  logic [31:0] exp_pc;
  logic        rdy, men, g;
  logic [31:0] wrap_addr[4];

  initial begin
    //            ena take pcn         gnt rdy men  req addr        dv  dpc
    vecs[0]  = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h0,      0, 32'h0);
    vecs[1]  = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h4,      0, 32'h0);
    vecs[2]  = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h8,      1, 32'h0);
    vecs[3]  = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'hC,      1, 32'h4);
    vecs[4]  = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h10,     1, 32'h8);
    vecs[5]  = mk(1, 0, 32'h0,         1, 0, 1,   1, 32'h14,     1, 32'hC);
    vecs[6]  = mk(1, 0, 32'h0,         1, 0, 1,   1, 32'h18,     1, 32'hC);
    vecs[7]  = mk(1, 0, 32'h0,         1, 0, 1,   0, 32'h1C,     1, 32'hC);
    vecs[8]  = mk(1, 0, 32'h0,         1, 0, 1,   0, 32'h1C,     1, 32'hC);
    vecs[9]  = mk(1, 0, 32'h0,         1, 1, 1,   0, 32'h1C,     1, 32'hC);
    vecs[10] = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h1C,     1, 32'h10);
    vecs[11] = mk(1, 0, 32'h0,         1, 1, 0,   1, 32'h20,     1, 32'h14);
    vecs[12] = mk(1, 1, 32'h100,       1, 1, 0,   0, 32'h24,     0, 32'h0);
    vecs[13] = mk(1, 0, 32'h0,         1, 1, 1,   0, 32'h100,    0, 32'h0);
    vecs[14] = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h100,    0, 32'h0);
    vecs[15] = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h104,    0, 32'h0);
    vecs[16] = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h108,    1, 32'h100);
    vecs[17] = mk(1, 0, 32'h0,         1, 1, 1,   1, 32'h10C,    1, 32'h104);

    do_reset();
    cyc(0, 0, 0, 32'h0, 0, 0, 1);

    // Startup, backpressure until full, then redirect with two requests in flight
    for (int i = 0; i < 18; i++) begin
      cyc(vecs[i].ena, 1'b0, vecs[i].take, vecs[i].pcn, vecs[i].gnt, vecs[i].ready, vecs[i].men);
      $display("vec %0d: req=%b addr=%08h dv=%b pc=%08h instr=%08h",
               i, imem_req, imem_addr, dec_valid, dec_pc, dec_instr);
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_dv", i), 32'(dec_valid), 32'(vecs[i].exp_dv));
      if (vecs[i].exp_dv) begin
        chk($sformatf("v%0d_pc", i), dec_pc, vecs[i].exp_dpc);
        chk($sformatf("v%0d_instr", i), dec_instr, f_instr(vecs[i].exp_dpc));
        chk($sformatf("v%0d_pc_next", i), dec_pc_next, vecs[i].exp_dpc + 32'd4);
      end else begin
        chk($sformatf("v%0d_pc_zero", i), dec_pc, 32'h0);
        chk($sformatf("v%0d_instr_zero", i), dec_instr, 32'h0);
      end
    end

    // Capture while disabled, then kill while disabled with a response in the kill cycle
    do_reset();
    cyc(1, 0, 0, 32'h0, 1, 0, 1);
    chk("dis_req0", 32'(imem_req), 32'd1);
    cyc(0, 0, 0, 32'h0, 1, 0, 1);
    chk("dis_req_off", 32'(imem_req), 32'd0);
    chk("dis_dv_off", 32'(dec_valid), 32'd0);
    cyc(0, 0, 0, 32'h0, 1, 0, 1);
    chk("dis_dv_off2", 32'(dec_valid), 32'd0);
    cyc(1, 0, 0, 32'h0, 1, 0, 1);
    $display("disabled capture: dv=%b pc=%08h instr=%08h", dec_valid, dec_pc, dec_instr);
    chk("dis_captured_dv", 32'(dec_valid), 32'd1);
    chk("dis_captured_pc", dec_pc, 32'h0);
    chk("dis_captured_instr", dec_instr, f_instr(32'h0));
    chk("dis_next_addr", imem_addr, 32'h4);
    cyc(0, 1, 0, 32'h0, 1, 0, 1);
    chk("kill_req", 32'(imem_req), 32'd0);
    chk("kill_dv", 32'(dec_valid), 32'd0);
    cyc(0, 0, 0, 32'h0, 1, 0, 1);
    $display("after kill: fetch_pc=%08h", fetch_pc);
    chk("kill_fetch_pc", fetch_pc, 32'h0);
    cyc(1, 0, 0, 32'h0, 0, 0, 1);
    chk("kill_empty_dv", 32'(dec_valid), 32'd0);
    chk("kill_req_again", 32'(imem_req), 32'd1);
    chk("kill_addr", imem_addr, 32'h0);
    cyc(1, 0, 0, 32'h0, 1, 1, 1);
    cyc(1, 0, 0, 32'h0, 0, 1, 1);
    cyc(1, 0, 0, 32'h0, 0, 1, 1);
    chk("kill_refetch_dv", 32'(dec_valid), 32'd1);
    chk("kill_refetch_pc", dec_pc, 32'h0);

    // Address wrap at 2^32 and repeated pointer wrap under irregular handshakes
    do_reset();
    wrap_addr[0] = 32'h0;
    wrap_addr[1] = 32'hFFFF_FFF8;
    wrap_addr[2] = 32'hFFFF_FFFC;
    wrap_addr[3] = 32'h0000_0000;
    cyc(1, 0, 1, 32'hFFFF_FFF8, 1, 1, 1);
    chk("wrap_redir_req", 32'(imem_req), 32'd0);
    chk("wrap_redir_dv", 32'(dec_valid), 32'd0);
    exp_pc = 32'hFFFF_FFF8;
    deq_n  = 0;
    for (int i = 1; i <= 60; i++) begin
      rdy = (i % 3 != 2);
      men = (i % 5 != 3);
      g   = (i % 7 != 6);
      cyc(1, 0, 0, 32'h0, g, rdy, men);
      if (i <= 3) begin
        chk($sformatf("wrap_req%0d", i), 32'(imem_req), 32'd1);
        chk($sformatf("wrap_addr%0d", i), imem_addr, wrap_addr[i]);
      end
      if (dec_valid && rdy) begin
        $display("wrap deq %0d: pc=%08h instr=%08h", deq_n, dec_pc, dec_instr);
        chk($sformatf("wrap_pc%0d", deq_n), dec_pc, exp_pc);
        chk($sformatf("wrap_instr%0d", deq_n), dec_instr, f_instr(exp_pc));
        chk($sformatf("wrap_next%0d", deq_n), dec_pc_next, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        deq_n++;
      end
    end
    chk("wrap_enough_deqs", 32'(deq_n >= 12), 32'd1);

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    chk("perf_rst_fetched", perf_fetched, 32'd0);
    chk("perf_rst_stall", perf_stall, 32'd0);
    chk("perf_rst_flushed", perf_flushed, 32'd0);
    repeat (3) cyc(1, 0, 0, 32'h0, 1, 0, 1);
    repeat (2) cyc(1, 0, 0, 32'h0, 0, 0, 1);
    cyc(1, 0, 1, 32'h200, 0, 0, 1);
    cyc(1, 0, 0, 32'h0, 0, 0, 1);
    $display("perf after flush: flushed=%0d", perf_flushed);
    chk("perf_flushed", perf_flushed, 32'd3);
    chk("perf_stall_none", perf_stall, 32'd0);
    deq_n = 0;
    for (int i = 0; i < 40 && deq_n < 5; i++) begin
      cyc(1, 0, 0, 32'h0, 1, 1, 1);
      if (dec_valid) deq_n++;
    end
    cyc(1, 0, 0, 32'h0, 0, 0, 1);
    $display("perf: fetched=%0d stall=%0d", perf_fetched, perf_stall);
    chk("perf_deq_seen", 32'(deq_n), 32'd5);
    chk("perf_fetched", perf_fetched, 32'd5);
    chk("perf_stall", perf_stall, 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
